// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam int XLEN    = 32;
  localparam int ILEN    = 32;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    BOOT  = 1'b0,
    FETCH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Register-based synchronous FIFO with clear; the head word comes straight
// from storage, so a push is never visible on data_o in its own cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A push into a full FIFO is legal when the head leaves on the same edge.
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (!do_push && do_pop) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch front end: credit-limited in-order memory reads feeding
// a {pc, instr} queue towards Decode, with squash on an Execute redirect.
module instr_prefetch
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH      = XLEN,
  parameter int                    INSTR_WIDTH     = ILEN,
  parameter int                    DEPTH           = 4,
  parameter int                    MAX_OUTSTANDING = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_PC        = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   redirect_i,
  input  logic [DATA_WIDTH-1:0]  redirect_pc_i,
  output logic                   mem_req_o,
  output logic [DATA_WIDTH-1:0]  mem_addr_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_rvalid_i,
  input  logic [INSTR_WIDTH-1:0] mem_rdata_i,
  output logic                   instr_valid_o,
  input  logic                   instr_ready_i,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0]  pc_o,
  output logic [DATA_WIDTH-1:0]  pc_4_o
);

  localparam int EW  = DATA_WIDTH + INSTR_WIDTH;
  localparam int QCW = $clog2(DEPTH + 1);
  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);

  fetch_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [OW-1:0]         outstanding_q, outstanding_d;
  logic [OW-1:0]         discard_q, discard_d;

  logic                  grant, drop_rsp, accept_rsp, pop;
  logic [EW-1:0]         q_rdata;
  logic [QCW-1:0]        q_count;
  logic                  q_full, q_empty;
  logic [DATA_WIDTH-1:0] side_pc;
  logic [OW-1:0]         side_count;
  logic                  side_full, side_empty;
  logic [DATA_WIDTH-1:0] head_pc;
  logic                  unused_status;

  assign grant      = mem_req_o && mem_gnt_i;
  assign drop_rsp   = mem_rvalid_i && (discard_q != '0);
  assign accept_rsp = mem_rvalid_i && (discard_q == '0) && !redirect_i;
  assign pop        = instr_valid_o && instr_ready_i && !redirect_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= BOOT;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = FETCH;
      FETCH:   state_d = FETCH;
      default: state_d = BOOT;
    endcase
  end

  // Queue slots already promised to in-flight reads count as occupied.
  always_comb begin
    mem_req_o = 1'b0;
    if (state_q == FETCH) begin
      mem_req_o = ((32'(q_count) + 32'(outstanding_q)) < 32'(DEPTH)) &&
                  (32'(outstanding_q) < 32'(MAX_OUTSTANDING));
    end
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (grant && !mem_rvalid_i)      outstanding_d = outstanding_q + OW'(1);
    else if (!grant && mem_rvalid_i) outstanding_d = outstanding_q - OW'(1);

    discard_d  = discard_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect_i) begin
      // Every read still in flight after this edge belongs to the old path.
      discard_d  = outstanding_d;
      fetch_pc_d = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
    end else begin
      if (drop_rsp) discard_d  = discard_q - OW'(1);
      if (grant)    fetch_pc_d = fetch_pc_q + DATA_WIDTH'(PC_STEP);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pc_side_q (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (redirect_i),
    .push_i  (grant && !redirect_i),
    .data_i  (fetch_pc_q),
    .pop_i   (accept_rsp),
    .data_o  (side_pc),
    .count_o (side_count),
    .full_o  (side_full),
    .empty_o (side_empty)
  );

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_entry_q (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (redirect_i),
    .push_i  (accept_rsp),
    .data_i  ({side_pc, mem_rdata_i}),
    .pop_i   (pop),
    .data_o  (q_rdata),
    .count_o (q_count),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  assign unused_status = ^{side_count, side_full, side_empty, q_full};

  assign head_pc       = q_rdata[EW-1:INSTR_WIDTH];
  assign instr_valid_o = !q_empty;
  assign instr_o       = instr_valid_o ? q_rdata[INSTR_WIDTH-1:0] : '0;
  assign pc_o          = instr_valid_o ? head_pc : '0;
  assign pc_4_o        = instr_valid_o ? head_pc + DATA_WIDTH'(PC_STEP) : '0;
  assign mem_addr_o    = fetch_pc_q;

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed and randomized bench for instr_prefetch with an in-order memory
// model and an expected-entry scoreboard.
module tb_instr_prefetch;
  import fetch_pkg::*;

  localparam int          W        = $bits(fetch_entry_t);
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_4_o;

  always #5 clk_i = ~clk_i;

  instr_prefetch #(
    .DATA_WIDTH      (32),
    .INSTR_WIDTH     (32),
    .DEPTH           (4),
    .MAX_OUTSTANDING (2),
    .RESET_PC        (RESET_PC)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .pc_4_o        (pc_4_o)
  );

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [W-1:0] exp_q[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          last_due;
  logic [31:0] exp_fetch_pc;
  int          gnt_mode;  // 0: always grant, 1: random, 2: never
  int          lat_min, lat_max;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h5a3c, ~a[17:2]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %h, want %h", tag, obs, expv);
    end
  endtask

  // Memory model: called at the negedge, drives gnt/rvalid for the coming edge.
  task automatic mem_drive();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    if (!rst_ni) begin
      mem_gnt_i = 1'b0;
      return;
    end
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = instr_of(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    case (gnt_mode)
      0:       mem_gnt_i = 1'b1;
      1:       mem_gnt_i = ($urandom_range(0, 2) != 0);
      default: mem_gnt_i = 1'b0;
    endcase
    if (mem_req_o) chk("req_addr", mem_addr_o, exp_fetch_pc);
    if (mem_req_o && mem_gnt_i) begin
      int due;
      due = cyc + int'($urandom_range(lat_min, lat_max));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend_addr.push_back(mem_addr_o);
      pend_due.push_back(due);
      if (!redirect_i) begin
        exp_q.push_back({exp_fetch_pc, instr_of(exp_fetch_pc)});
        exp_fetch_pc = exp_fetch_pc + 32'd4;
      end
    end
    if (redirect_i) exp_fetch_pc = {redirect_pc_i[31:2], 2'b00};
  endtask

  task automatic observe();
    logic [W-1:0] e;
    logic [31:0]  p4;
    if (!rst_ni) return;
    if (redirect_i) begin
      exp_q.delete();
      return;
    end
    if (instr_valid_o && instr_ready_i) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL out_unexpected: got pc %h instr %h, want no entry", pc_o, instr_o);
      end
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        p4 = e[63:32] + 32'd4;
        chk("out_entry", {pc_o, instr_o}, e);
        chk("out_pc4", pc_4_o, p4);
      end
    end
  endtask

  task automatic step();
    mem_drive();
    observe();
    @(negedge clk_i);
    cyc++;
  endtask

  task automatic apply_reset();
    rst_ni       = 1'b0;
    redirect_i   = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    pend_addr.delete();
    pend_due.delete();
    exp_q.delete();
    exp_fetch_pc = RESET_PC;
    last_due     = cyc;
    repeat (2) begin
      @(negedge clk_i);
      cyc++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"},   mem_req_o, 0);
    chk({tag, "_addr"},  mem_addr_o, RESET_PC);
    chk({tag, "_valid"}, instr_valid_o, 0);
    chk({tag, "_instr"}, instr_o, 0);
    chk({tag, "_pc"},    pc_o, 0);
    chk({tag, "_pc4"},   pc_4_o, 0);
  endtask

  task automatic wait_pend(input string tag, input int n);
    int k = 0;
    while (pend_addr.size() != n && k < 50) begin
      step();
      k++;
    end
    chk(tag, pend_addr.size(), n);
  endtask

  task automatic wait_valid(input string tag, input logic [31:0] want_pc);
    int k = 0;
    while (!instr_valid_o && k < 50) begin
      step();
      k++;
    end
    chk(tag, {instr_valid_o, pc_o}, {1'b1, want_pc});
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_i    = 1'b1;
    redirect_pc_i = target;
    step();
    redirect_i    = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want test end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_ni        = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    mem_gnt_i     = 1'b0;
    mem_rvalid_i  = 1'b0;
    mem_rdata_i   = '0;
    instr_ready_i = 1'b0;
    gnt_mode      = 0;
    lat_min       = 1;
    lat_max       = 1;
    @(negedge clk_i);
    apply_reset();
    check_reset_outputs("rst0");

    // Release: BOOT for one edge, grant on the next, entry visible after the third.
    instr_ready_i = 1'b1;
    rst_ni        = 1'b1;
    chk("boot_req", mem_req_o, 0);
    step();
    chk("first_req", mem_req_o, 1);
    chk("first_addr", mem_addr_o, RESET_PC);
    step();
    chk("valid_early", instr_valid_o, 0);
    chk("second_addr", mem_addr_o, RESET_PC + 32'd4);
    step();
    chk("first_valid", instr_valid_o, 1);
    chk("first_pc", pc_o, RESET_PC);
    chk("first_pc4", pc_4_o, RESET_PC + 32'd4);
    repeat (12) step();

    // Back-pressure: exactly DEPTH entries accepted, then requests stop.
    instr_ready_i = 1'b0;
    repeat (10) step();
    chk("bp_valid", instr_valid_o, 1);
    chk("bp_req", mem_req_o, 0);
    chk("bp_queued", exp_q.size(), 4);
    instr_ready_i = 1'b1;
    repeat (10) step();

    // Redirect with two reads in flight.
    lat_min = 3;
    lat_max = 3;
    wait_pend("rd1_setup", 2);
    do_redirect(32'h0000_0100);
    chk("rd1_empty", instr_valid_o, 0);
    chk("rd1_addr", mem_addr_o, 32'h0000_0100);
    wait_valid("rd1_pc", 32'h0000_0100);
    repeat (6) step();

    // Redirect coinciding with a grant and a pop.
    lat_min = 1;
    lat_max = 1;
    for (int k = 0; k < 50 && !(instr_valid_o && mem_req_o); k++) step();
    chk("rd2_setup", {instr_valid_o, mem_req_o}, 2'b11);
    do_redirect(32'h0000_0300);
    chk("rd2_addr", mem_addr_o, 32'h0000_0300);
    chk("rd2_empty", instr_valid_o, 0);
    wait_valid("rd2_pc", 32'h0000_0300);

    // Grant withheld: address must stay put.
    gnt_mode = 2;
    repeat (2) step();
    for (int k = 0; k < 5; k++) begin
      chk("hold_req", mem_req_o, 1);
      chk("hold_addr", mem_addr_o, exp_fetch_pc);
      step();
    end

    // Random grant, latency and ready, with a few redirects including wrap.
    gnt_mode = 1;
    lat_min  = 1;
    lat_max  = 4;
    for (int k = 0; k < 240; k++) begin
      instr_ready_i = ($urandom_range(0, 3) != 0);
      if (k == 80) begin
        do_redirect(32'h0000_0403);
        chk("misalign_addr", mem_addr_o, 32'h0000_0400);
      end else if (k == 150) begin
        do_redirect(32'hFFFF_FFF8);
        chk("wrap_addr", mem_addr_o, 32'hFFFF_FFF8);
      end else if (k > 200 && $urandom_range(0, 19) == 0) begin
        do_redirect($urandom_range(0, 32'h0000_ffff));
      end else begin
        step();
      end
    end

    // Reset with two reads in flight.
    instr_ready_i = 1'b1;
    gnt_mode      = 0;
    lat_min       = 3;
    lat_max       = 3;
    wait_pend("rst1_setup", 2);
    apply_reset();
    check_reset_outputs("rst1");
    rst_ni = 1'b1;
    lat_min = 1;
    lat_max = 2;
    wait_valid("rst1_pc", RESET_PC);
    repeat (20) step();

    // Drain: no new grants; everything granted must come out.
    gnt_mode = 2;
    for (int k = 0; k < 40 && (pend_addr.size() != 0 || instr_valid_o); k++) step();
    chk("drain_left", exp_q.size(), 0);
    chk("drain_valid", instr_valid_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
